// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with prescaler, synchronous load and a
// registered terminal-count pulse; wraps or saturates at the range ends.
module counter_mod #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_tc;

  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_count;

  assign w_step         = en && (r_pre == PRE_LAST);
  assign w_at_max       = (r_count == MAX);
  assign w_at_zero      = (r_count == '0);
  assign w_at_bound     = up ? w_at_max : w_at_zero;
  assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

  // Boundary is tested before the add/subtract, so a MAX below the full
  // register range can never be overshot.
  always_comb begin
    w_next_count = r_count;
    if (up) begin
      if (!w_at_max)      w_next_count = r_count + 1'b1;
      else if (!SATURATE) w_next_count = '0;
    end else begin
      if (!w_at_zero)     w_next_count = r_count - 1'b1;
      else if (!SATURATE) w_next_count = MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next_count;
      r_pre   <= '0;
      r_tc    <= w_at_bound;
    end else if (en) begin
      r_pre   <= r_pre + 1'b1;
      r_tc    <= 1'b0;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign zero  = (r_count == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: five parameterisations share one stimulus
// bus; each scenario task checks only the instance it targets.
module tb_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
  logic       tc_a, tc_b, tc_c, tc_d, tc_e;
  logic       zero_a, zero_b, zero_c, zero_d, zero_e;

  always #5 clk = ~clk;

  counter_mod #(.WIDTH(4), .MAX(4'd15), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_a), .tc(tc_a), .zero(zero_a));
  counter_mod #(.WIDTH(4), .MAX(4'd9), .PRESCALE(1), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_b), .tc(tc_b), .zero(zero_b));
  counter_mod #(.WIDTH(4), .MAX(4'd15), .PRESCALE(3), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_c), .tc(tc_c), .zero(zero_c));
  counter_mod #(.WIDTH(4), .MAX(4'd5), .PRESCALE(1), .SATURATE(1'b1)) u_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_d), .tc(tc_d), .zero(zero_d));
  counter_mod #(.WIDTH(4), .MAX(4'd15), .PRESCALE(2), .SATURATE(1'b0)) u_e (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_e), .tc(tc_e), .zero(zero_e));

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       zero;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    exp_t       exp;
  } stim_t;

  stim_t st[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;

  function automatic stim_t s(logic r, logic e, logic u, logic l, int v, int c, logic t);
    stim_t x;
    x.rst       = r;
    x.en        = e;
    x.up        = u;
    x.load      = l;
    x.lv        = 4'(v);
    x.exp.count = 4'(c);
    x.exp.tc    = t;
    x.exp.zero  = (c == 0);
    return x;
  endfunction

  // Drives one cycle of stimulus and records its expected outcome.
  task automatic drive_next();
    stim_t x;
    x = st.pop_front();
    @(negedge clk);
    rst      = x.rst;
    en       = x.en;
    up       = x.up;
    load     = x.load;
    load_val = x.lv;
    sb.push_back(x.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t a, e;
    int   n;
    st.push_back(s(1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 18; i++) st.push_back(s(0, 1, 1, 0, 0, i % 16, (i % 16) == 0));
    n = 0;
    while (st.size() > 0) begin
      drive_next();
      a = {cnt_a, tc_a, zero_a};
      e = sb.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL reset_basic[%0d]: got count=%0d tc=%0b zero=%0b, need count=%0d tc=%0b zero=%0b",
                 n, a.count, a.tc, a.zero, e.count, e.tc, e.zero);
      end
      n++;
    end
  endtask

  task automatic test_modulus_down();
    exp_t a, e;
    int   n;
    st.push_back(s(1, 0, 0, 0, 0, 0, 0));
    st.push_back(s(0, 1, 1, 1, 2, 2, 0));   // load wins over en
    st.push_back(s(0, 1, 0, 0, 0, 1, 0));
    st.push_back(s(0, 1, 0, 0, 0, 0, 0));
    st.push_back(s(0, 1, 0, 0, 0, 9, 1));
    st.push_back(s(0, 1, 0, 0, 0, 8, 0));
    st.push_back(s(0, 0, 0, 1, 12, 9, 0));  // clamp to MAX
    st.push_back(s(0, 1, 1, 0, 0, 0, 1));   // up-wrap at MAX=9
    st.push_back(s(0, 1, 1, 0, 0, 1, 0));
    n = 0;
    while (st.size() > 0) begin
      drive_next();
      a = {cnt_b, tc_b, zero_b};
      e = sb.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL modulus_down[%0d]: got count=%0d tc=%0b zero=%0b, need count=%0d tc=%0b zero=%0b",
                 n, a.count, a.tc, a.zero, e.count, e.tc, e.zero);
      end
      n++;
    end
  endtask

  task automatic test_prescaler();
    exp_t a, e;
    int   n;
    st.push_back(s(1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) st.push_back(s(0, 1, 1, 0, 0, i / 3, 0));
    st.push_back(s(0, 1, 1, 0, 0, 3, 0));
    st.push_back(s(0, 0, 1, 0, 0, 3, 0));
    st.push_back(s(0, 0, 1, 0, 0, 3, 0));
    st.push_back(s(0, 1, 1, 0, 0, 3, 0));
    st.push_back(s(0, 1, 1, 0, 0, 4, 0));
    n = 0;
    while (st.size() > 0) begin
      drive_next();
      a = {cnt_c, tc_c, zero_c};
      e = sb.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL prescaler[%0d]: got count=%0d tc=%0b zero=%0b, need count=%0d tc=%0b zero=%0b",
                 n, a.count, a.tc, a.zero, e.count, e.tc, e.zero);
      end
      n++;
    end
  endtask

  task automatic test_saturate();
    exp_t a, e;
    int   n;
    st.push_back(s(1, 0, 0, 0, 0, 0, 0));
    st.push_back(s(0, 0, 1, 1, 4, 4, 0));
    st.push_back(s(0, 1, 1, 0, 0, 5, 0));   // 4->5 is not a boundary step
    st.push_back(s(0, 1, 1, 0, 0, 5, 1));
    st.push_back(s(0, 1, 1, 0, 0, 5, 1));
    st.push_back(s(0, 1, 1, 0, 0, 5, 1));
    st.push_back(s(0, 1, 0, 0, 0, 4, 0));
    st.push_back(s(0, 0, 0, 1, 0, 0, 0));
    st.push_back(s(0, 1, 0, 0, 0, 0, 1));
    st.push_back(s(0, 1, 0, 0, 0, 0, 1));
    n = 0;
    while (st.size() > 0) begin
      drive_next();
      a = {cnt_d, tc_d, zero_d};
      e = sb.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL saturate[%0d]: got count=%0d tc=%0b zero=%0b, need count=%0d tc=%0b zero=%0b",
                 n, a.count, a.tc, a.zero, e.count, e.tc, e.zero);
      end
      n++;
    end
  endtask

  task automatic test_priority();
    exp_t a, e;
    int   n;
    st.push_back(s(1, 0, 0, 0, 0, 0, 0));
    st.push_back(s(0, 1, 1, 0, 0, 0, 0));
    st.push_back(s(0, 1, 1, 0, 0, 1, 0));
    st.push_back(s(0, 1, 1, 0, 0, 1, 0));
    st.push_back(s(0, 1, 1, 1, 7, 7, 0));   // load on a step cycle
    st.push_back(s(0, 1, 1, 0, 0, 7, 0));
    st.push_back(s(0, 1, 1, 0, 0, 8, 0));
    st.push_back(s(1, 1, 1, 1, 5, 0, 0));   // rst beats load
    st.push_back(s(0, 0, 1, 1, 15, 15, 0));
    st.push_back(s(0, 1, 1, 0, 0, 15, 0));
    st.push_back(s(0, 1, 1, 0, 0, 0, 1));
    st.push_back(s(1, 1, 1, 0, 0, 0, 0));   // rst clears pending tc
    st.push_back(s(0, 1, 1, 0, 0, 0, 0));
    st.push_back(s(0, 1, 1, 0, 0, 1, 0));
    n = 0;
    while (st.size() > 0) begin
      drive_next();
      a = {cnt_e, tc_e, zero_e};
      e = sb.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL priority[%0d]: got count=%0d tc=%0b zero=%0b, need count=%0d tc=%0b zero=%0b",
                 n, a.count, a.tc, a.zero, e.count, e.tc, e.zero);
      end
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, need finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_modulus_down();
    test_prescaler();
    test_saturate();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter with synchronous load, enable, clock prescaler and terminal-count pulse. It generalises the fixed 4-bit free-running counter to any width and modulus, with selectable wrap or saturate behaviour. It serves as the general timebase/event counter for lab datapaths, for example display refresh dividers, debounce timers and sequence indices.

## Interface
Parameters:
- WIDTH, 8, count register width in bits (≥ 1)
- MAX, 2**WIDTH-1, largest count value; counting range is 0..MAX (MAX ≤ 2**WIDTH-1)
- PRESCALE, 1, number of enabled cycles per count step (≥ 1)
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; advances the prescaler
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on each step cycle
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered)
- zero  out  1  count == 0 (combinational from the count register)

## Operation
- Internal prescaler `pre` has width max(1, clog2(PRESCALE)) and range 0..PRESCALE-1.
- A step occurs on a cycle where en=1 and pre==PRESCALE-1. With PRESCALE=1, every enabled cycle is a step.
- Priority per cycle is rst > load > en:
  - rst: count=0, pre=0, tc=0.
  - load: count=min(load_val, MAX), pre=0, tc=0. en is ignored in that cycle.
  - en=1, no step: pre increments, count is held, tc=0.
  - en=1, step: pre=0, and count updates as follows:
    - up=1, count<MAX: count+1
    - up=1, count==MAX: 0 when SATURATE=0; holds MAX when SATURATE=1
    - up=0, count>0: count-1
    - up=0, count==0: MAX when SATURATE=0; holds 0 when SATURATE=1
    - tc=1 only for a step taken at the boundary in the current direction (count==MAX with up=1, or count==0 with up=0). Otherwise tc=0.
  - en=0: count and pre are held, tc=0.
- No internal arithmetic overflows WIDTH. The boundary compare happens before the add/subtract, so MAX < 2**WIDTH-1 never produces out-of-range values.
- A direction change mid-prescale takes effect at the next step. pre is unaffected.

## Timing
- Reset values: count=0, tc=0, zero=1, pre=0.
- Latency:
  - count changes on the edge following the step/load cycle.
  - tc is high for exactly the one cycle in which count shows the post-step value.
- tc is never high on two consecutive cycles unless PRESCALE=1 and the boundary condition persists. Example: SATURATE=1 with en held gives tc on every cycle.
- Load mid-prescale discards the partial prescale count. The first step after a load needs a full PRESCALE enabled cycles.
- rst asserted mid-operation overrides load and en in the same cycle. Counting resumes on the first cycle after rst deasserts.
- zero follows count with no extra register stage.

## Test plan
- Reset/basic, WIDTH=4, MAX=15, PRESCALE=1: rst 1 cycle, then en=1, up=1 for 18 cycles.
  - Required: count goes 0,1,…,15,0,1.
  - tc is high only in the cycle count shows 0 after 15.
  - zero is high at reset and at the wrap.
- Modulus/down, MAX=9: load 2, then up=0, en=1.
  - Required: count 2,1,0,9,8.
  - tc is high with count=9.
  - load_val=12 loads 9 (clamp).
- Prescaler, PRESCALE=3, MAX=15: en=1 continuously from count=0.
  - Required: count increments every 3rd cycle.
  - Dropping en for 2 cycles mid-prescale delays the next step by exactly 2 cycles.
- Saturate, SATURATE=1, MAX=5: load 4, up=1, en=1 for 4 cycles.
  - Required: count 5,5,5,5.
  - tc is high on every step at 5.
  - up=0 then gives 4 with tc=0.
- Priority/simultaneous, PRESCALE=2:
  - load=1 with en=1 on a step cycle: count=load_val and pre is reset, so the next step comes 2 cycles later.
  - rst=1 together with load=1: count=0.
  - rst asserted while tc=1: tc=0 on the next cycle.
